// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - stream input and status outputs of the LFSR checker
interface lfsr_checker_if #(
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     en;
    logic                     data_in;
    logic                     clear_errs;
    logic                     locked;
    logic                     err;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [1:0]               sync_state;

    modport master (
        output en, data_in, clear_errs,
        input  locked, err, err_count, sync_state
    );

    modport slave (
        input  en, data_in, clear_errs,
        output locked, err, err_count, sync_state
    );
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the core lfsr serial stream
module lfsr_checker #(
    parameter int WIDTH         = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_ERRS   = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_checker_if.slave      bus
);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Tap positions shared with the generator; bit n-1 set for tap n.
    function automatic logic [WIDTH-1:0] tap_mask();
        logic [15:0] m;
        case (WIDTH)
            3:       m = 16'b0000_0000_0000_0110;
            4:       m = 16'b0000_0000_0000_1100;
            5:       m = 16'b0000_0000_0001_0100;
            6:       m = 16'b0000_0000_0011_0000;
            7:       m = 16'b0000_0000_0110_0000;
            8:       m = 16'b0000_0000_1011_1000;
            9:       m = 16'b0000_0001_0001_0000;
            10:      m = 16'b0000_0010_0100_0000;
            11:      m = 16'b0000_0101_0000_0000;
            12:      m = 16'b0000_1000_0010_1001;
            13:      m = 16'b0001_0000_0000_1101;
            14:      m = 16'b0010_0000_0001_0101;
            15:      m = 16'b0110_0000_0000_0000;
            default: m = 16'b1101_0000_0000_1000;
        endcase
        return m[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] TAPS = tap_mask();

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         sr_q, sr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [MATCH_W-1:0]       match_q, match_d;
    logic [MISS_W-1:0]        miss_q, miss_d;
    logic                     locked_q, locked_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                     pred;
    logic [ERR_CNT_WIDTH-1:0] cnt_base;
    logic [FILL_W-1:0]        fill_inc;
    logic [MATCH_W-1:0]       match_inc;
    logic [MISS_W-1:0]        miss_inc;

    assign pred      = (~^(sr_q & TAPS)) ^ (|sr_q[WIDTH-2:0]);
    assign fill_inc  = fill_q + FILL_W'(1);
    assign match_inc = match_q + MATCH_W'(1);
    assign miss_inc  = miss_q + MISS_W'(1);
    // Clearing applies first so a same-cycle mismatch still counts once.
    assign cnt_base  = bus.clear_errs ? '0 : err_count_q;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = cnt_base;
        if (bus.en) begin
            case (state_q)
                SEED: begin
                    sr_d   = {sr_q[WIDTH-2:0], bus.data_in};
                    fill_d = fill_inc;
                    if (fill_inc == FILL_W'(WIDTH)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.data_in};
                    if (bus.data_in == pred) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the register runs on its own prediction.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (bus.data_in != pred) begin
                        err_d       = 1'b1;
                        err_count_d = (&cnt_base) ? cnt_base : cnt_base + ERR_CNT_WIDTH'(1);
                        miss_d      = miss_inc;
                        if (miss_inc == MISS_W'(UNLOCK_ERRS)) begin
                            state_d  = SEED;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            match_d  = '0;
                            miss_d   = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                    fill_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.err_count  = err_count_q;
    assign bus.sync_state = state_q;
endmodule
